// File: rtl/mem_rr_arbiter_2to1.sv
// Two-to-one round-robin MEM arbiter: merges instruction and data master ports
// onto one shared port and routes in-order responses back via an ID FIFO.
module mem_rr_arbiter_2to1 #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    s0_mem_req,
    output logic                    s0_mem_gnt,
    input  logic [ADDR_WIDTH-1:0]   s0_mem_addr,
    input  logic                    s0_mem_we,
    input  logic [DATA_WIDTH/8-1:0] s0_mem_be,
    input  logic [DATA_WIDTH-1:0]   s0_mem_wdata,
    output logic                    s0_mem_valid,
    output logic [DATA_WIDTH-1:0]   s0_mem_rdata,
    output logic                    s0_mem_error,
    input  logic                    s1_mem_req,
    output logic                    s1_mem_gnt,
    input  logic [ADDR_WIDTH-1:0]   s1_mem_addr,
    input  logic                    s1_mem_we,
    input  logic [DATA_WIDTH/8-1:0] s1_mem_be,
    input  logic [DATA_WIDTH-1:0]   s1_mem_wdata,
    output logic                    s1_mem_valid,
    output logic [DATA_WIDTH-1:0]   s1_mem_rdata,
    output logic                    s1_mem_error,
    output logic                    m_mem_req,
    input  logic                    m_mem_gnt,
    output logic [ADDR_WIDTH-1:0]   m_mem_addr,
    output logic                    m_mem_we,
    output logic [DATA_WIDTH/8-1:0] m_mem_be,
    output logic [DATA_WIDTH-1:0]   m_mem_wdata,
    input  logic                    m_mem_valid,
    input  logic [DATA_WIDTH-1:0]   m_mem_rdata,
    input  logic                    m_mem_error,
    output logic                    spurious_rsp_o
);
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

    typedef enum logic {ST_ARB = 1'b0, ST_LOCKED = 1'b1} state_t;

    state_t                     r_state;
    logic                       r_sel;
    logic                       r_last_grant;
    logic [MAX_OUTSTANDING-1:0] r_fifo;
    logic [PTR_W-1:0]           r_wptr;
    logic [PTR_W-1:0]           r_rptr;
    logic [CNT_W-1:0]           r_count;

    logic w_arb_sel;
    logic w_sel;
    logic w_req;
    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_head;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        if (p == PTR_LAST) begin
            ptr_next = {PTR_W{1'b0}};
        end else begin
            ptr_next = p + PTR_W'(1);
        end
    endfunction

    assign w_full  = (r_count == CNT_MAX);
    assign w_empty = (r_count == {CNT_W{1'b0}});
    assign w_push  = w_req && m_mem_gnt;
    assign w_pop   = m_mem_valid && !w_empty && !rst_i;
    assign w_head  = r_fifo[r_rptr];

    // Round-robin pick: on a tie the requester that did not win last time.
    always_comb begin
        w_arb_sel = 1'b0;
        if (s0_mem_req && s1_mem_req) begin
            w_arb_sel = ~r_last_grant;
        end else if (s1_mem_req) begin
            w_arb_sel = 1'b1;
        end else begin
            w_arb_sel = 1'b0;
        end
    end

    // A locked selection stays on the bus until granted or its requester drops out.
    always_comb begin
        w_sel = w_arb_sel;
        w_req = 1'b0;
        if (rst_i) begin
            w_req = 1'b0;
        end else if (r_state == ST_LOCKED) begin
            w_sel = r_sel;
            w_req = r_sel ? s1_mem_req : s0_mem_req;
        end else begin
            w_req = (s0_mem_req || s1_mem_req) && !w_full;
        end
    end

    assign m_mem_req   = w_req;
    assign m_mem_addr  = w_req ? (w_sel ? s1_mem_addr  : s0_mem_addr)  : {ADDR_WIDTH{1'b0}};
    assign m_mem_we    = w_req ? (w_sel ? s1_mem_we    : s0_mem_we)    : 1'b0;
    assign m_mem_be    = w_req ? (w_sel ? s1_mem_be    : s0_mem_be)    : {BE_W{1'b0}};
    assign m_mem_wdata = w_req ? (w_sel ? s1_mem_wdata : s0_mem_wdata) : {DATA_WIDTH{1'b0}};
    assign s0_mem_gnt  = w_push && !w_sel;
    assign s1_mem_gnt  = w_push &&  w_sel;

    assign s0_mem_valid   = w_pop && !w_head;
    assign s0_mem_rdata   = (w_pop && !w_head) ? m_mem_rdata : {DATA_WIDTH{1'b0}};
    assign s0_mem_error   = w_pop && !w_head && m_mem_error;
    assign s1_mem_valid   = w_pop && w_head;
    assign s1_mem_rdata   = (w_pop && w_head) ? m_mem_rdata : {DATA_WIDTH{1'b0}};
    assign s1_mem_error   = w_pop && w_head && m_mem_error;
    assign spurious_rsp_o = m_mem_valid && (rst_i || w_empty);

    // Arbitration FSM and round-robin history.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= ST_ARB;
            r_sel        <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            if (w_push) begin
                r_last_grant <= w_sel;
            end
            case (r_state)
                ST_ARB: begin
                    if (w_req && !m_mem_gnt) begin
                        r_state <= ST_LOCKED;
                        r_sel   <= w_sel;
                    end
                end
                ST_LOCKED: begin
                    if (!w_req || m_mem_gnt) begin
                        r_state <= ST_ARB;
                    end
                end
                default: r_state <= ST_ARB;
            endcase
        end
    end

    // In-order ID FIFO of outstanding transactions.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_fifo  <= {MAX_OUTSTANDING{1'b0}};
            r_wptr  <= {PTR_W{1'b0}};
            r_rptr  <= {PTR_W{1'b0}};
            r_count <= {CNT_W{1'b0}};
        end else begin
            if (w_push) begin
                r_fifo[r_wptr] <= w_sel;
                r_wptr         <= ptr_next(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_next(r_rptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_rr_arbiter_2to1.sv
// Self-checking bench for mem_rr_arbiter_2to1: directed scenarios plus random
// traffic compared cycle by cycle against a queue-based reference model.
module tb_mem_rr_arbiter_2to1;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int BW   = DW / 8;
    localparam int MAXO = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          s0_req, s1_req, s0_we, s1_we;
    logic [AW-1:0] s0_addr, s1_addr;
    logic [BW-1:0] s0_be, s1_be;
    logic [DW-1:0] s0_wdata, s1_wdata;
    logic          m_gnt, m_valid, m_error;
    logic [DW-1:0] m_rdata;

    logic          s0_gnt, s1_gnt, s0_valid, s1_valid, s0_err, s1_err;
    logic [DW-1:0] s0_rdata, s1_rdata;
    logic          m_req, m_we, spur;
    logic [AW-1:0] m_addr;
    logic [BW-1:0] m_be;
    logic [DW-1:0] m_wdata;

    mem_rr_arbiter_2to1 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)) dut (
        .clk_i(clk), .rst_i(rst),
        .s0_mem_req(s0_req), .s0_mem_gnt(s0_gnt), .s0_mem_addr(s0_addr), .s0_mem_we(s0_we),
        .s0_mem_be(s0_be), .s0_mem_wdata(s0_wdata), .s0_mem_valid(s0_valid),
        .s0_mem_rdata(s0_rdata), .s0_mem_error(s0_err),
        .s1_mem_req(s1_req), .s1_mem_gnt(s1_gnt), .s1_mem_addr(s1_addr), .s1_mem_we(s1_we),
        .s1_mem_be(s1_be), .s1_mem_wdata(s1_wdata), .s1_mem_valid(s1_valid),
        .s1_mem_rdata(s1_rdata), .s1_mem_error(s1_err),
        .m_mem_req(m_req), .m_mem_gnt(m_gnt), .m_mem_addr(m_addr), .m_mem_we(m_we),
        .m_mem_be(m_be), .m_mem_wdata(m_wdata), .m_mem_valid(m_valid),
        .m_mem_rdata(m_rdata), .m_mem_error(m_error), .spurious_rsp_o(spur)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state: outstanding requester IDs in order, last winner, committed requester.
    int q[$];
    int last_g = 1;
    int pend   = -1;

    logic          e_mreq, e_we, e_spur;
    int            e_sel;
    logic [AW-1:0] e_addr;
    logic [BW-1:0] e_be;
    logic [DW-1:0] e_wdata;
    logic          e_gnt0, e_gnt1, e_v0, e_v1, e_err0, e_err1;
    logic [DW-1:0] e_rd0, e_rd1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_eval();
        e_mreq = 1'b0; e_sel = 0; e_addr = '0; e_we = 1'b0; e_be = '0; e_wdata = '0;
        e_gnt0 = 1'b0; e_gnt1 = 1'b0; e_v0 = 1'b0; e_v1 = 1'b0;
        e_err0 = 1'b0; e_err1 = 1'b0; e_rd0 = '0; e_rd1 = '0; e_spur = 1'b0;
        if (rst) begin
            e_spur = m_valid;
        end else begin
            if (pend >= 0) begin
                e_sel  = pend;
                e_mreq = (pend == 0) ? s0_req : s1_req;
            end else begin
                e_mreq = (s0_req || s1_req) && (q.size() < MAXO);
                if (s0_req && s1_req) e_sel = 1 - last_g;
                else                  e_sel = s1_req ? 1 : 0;
            end
            if (e_mreq) begin
                e_addr  = (e_sel == 1) ? s1_addr  : s0_addr;
                e_we    = (e_sel == 1) ? s1_we    : s0_we;
                e_be    = (e_sel == 1) ? s1_be    : s0_be;
                e_wdata = (e_sel == 1) ? s1_wdata : s0_wdata;
            end
            e_gnt0 = m_gnt && e_mreq && (e_sel == 0);
            e_gnt1 = m_gnt && e_mreq && (e_sel == 1);
            if (m_valid) begin
                if (q.size() == 0) begin
                    e_spur = 1'b1;
                end else if (q[0] == 0) begin
                    e_v0 = 1'b1; e_rd0 = m_rdata; e_err0 = m_error;
                end else begin
                    e_v1 = 1'b1; e_rd1 = m_rdata; e_err1 = m_error;
                end
            end
        end
    endtask

    task automatic model_update();
        if (rst) begin
            q.delete();
            pend   = -1;
            last_g = 1;
        end else begin
            if (m_valid && q.size() > 0) void'(q.pop_front());
            if (e_mreq && m_gnt) begin
                q.push_back(e_sel);
                last_g = e_sel;
            end
            pend = (e_mreq && !m_gnt) ? e_sel : -1;
        end
    endtask

    task automatic compare_all();
        chk("m_req", m_req, e_mreq);
        chk("m_addr", m_addr, e_addr);
        chk("m_we", m_we, e_we);
        chk("m_be", m_be, e_be);
        chk("m_wdata", m_wdata, e_wdata);
        chk("s0_gnt", s0_gnt, e_gnt0);
        chk("s1_gnt", s1_gnt, e_gnt1);
        chk("s0_valid", s0_valid, e_v0);
        chk("s1_valid", s1_valid, e_v1);
        chk("s0_rdata", s0_rdata, e_rd0);
        chk("s1_rdata", s1_rdata, e_rd1);
        chk("s0_error", s0_err, e_err0);
        chk("s1_error", s1_err, e_err1);
        chk("spurious", spur, e_spur);
    endtask

    task automatic settle();
        #2;
        model_eval();
        compare_all();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic cyc();
        settle();
        tick();
    endtask

    task automatic idle();
        s0_req = 1'b0; s0_addr = '0; s0_we = 1'b0; s0_be = '0; s0_wdata = '0;
        s1_req = 1'b0; s1_addr = '0; s1_we = 1'b0; s1_be = '0; s1_wdata = '0;
        m_gnt = 1'b0; m_valid = 1'b0; m_rdata = '0; m_error = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        cyc();
        cyc();
        rst = 1'b0;
        settle();
        chk("rst_m_req", m_req, 1'b0);
        chk("rst_spur", spur, 1'b0);
        tick();

        // Single s0 read with a one-cycle response.
        s0_req = 1'b1; s0_addr = 32'h0000_0100; m_gnt = 1'b1;
        settle();
        chk("tp1_gnt", s0_gnt, 1'b1);
        chk("tp1_addr", m_addr, 64'h100);
        tick();
        idle();
        m_valid = 1'b1; m_rdata = 32'hDEAD_BEEF;
        settle();
        chk("tp1_valid", s0_valid, 1'b1);
        chk("tp1_rdata", s0_rdata, 64'hDEAD_BEEF);
        chk("tp1_s1_valid", s1_valid, 1'b0);
        tick();

        // Continuous contention alternates, s0 first after reset.
        do_reset();
        s0_req = 1'b1; s0_addr = 32'h0000_1000;
        s1_req = 1'b1; s1_addr = 32'h0000_2000; m_gnt = 1'b1;
        for (int i = 0; i < 6; i++) begin
            m_valid = (i > 0); m_rdata = 32'(i);
            settle();
            chk("tp2_alt_s0", s0_gnt, (i % 2) == 0);
            chk("tp2_alt_s1", s1_gnt, (i % 2) == 1);
            tick();
        end

        // s1 write stalled three cycles holds the bus while s0 joins.
        do_reset();
        s1_req = 1'b1; s1_we = 1'b1; s1_be = 4'hF; s1_wdata = 32'h1234_5678; s1_addr = 32'h0000_0200;
        s0_addr = 32'h0000_0300;
        for (int i = 0; i < 4; i++) begin
            s0_req = (i >= 1);
            m_gnt  = (i == 3);
            settle();
            chk("tp3_addr", m_addr, 64'h200);
            chk("tp3_wdata", m_wdata, 64'h1234_5678);
            chk("tp3_s1_gnt", s1_gnt, i == 3);
            chk("tp3_s0_gnt", s0_gnt, 1'b0);
            tick();
        end
        s1_req = 1'b0;
        settle();
        chk("tp3_s0_next", s0_gnt, 1'b1);
        tick();

        // Fill to capacity, then one response reopens the port.
        do_reset();
        s0_req = 1'b1; s1_req = 1'b1; m_gnt = 1'b1;
        for (int i = 0; i < 6; i++) begin
            settle();
            chk("tp4_full_req", m_req, i < 4);
            tick();
        end
        m_valid = 1'b1; m_error = 1'b1; m_rdata = 32'h0000_AA55;
        settle();
        chk("tp4_pop_blocked", m_req, 1'b0);
        chk("tp4_err_s0", s0_err, 1'b1);
        chk("tp4_err_s1", s1_err, 1'b0);
        tick();
        m_valid = 1'b0; m_error = 1'b0;
        settle();
        chk("tp4_reopen", m_req, 1'b1);
        tick();
        idle();
        for (int i = 0; i < 4; i++) begin
            m_valid = 1'b1; m_rdata = 32'(100 + i);
            settle();
            chk("tp4_route_s1", s1_valid, (i % 2) == 0);
            chk("tp4_route_s0", s0_valid, (i % 2) == 1);
            tick();
        end

        // Spurious responses: empty FIFO, and after reset with two outstanding.
        do_reset();
        m_valid = 1'b1;
        settle();
        chk("tp5_spur_empty", spur, 1'b1);
        chk("tp5_no_valid", s0_valid | s1_valid, 1'b0);
        tick();
        m_valid = 1'b0; s0_req = 1'b1; m_gnt = 1'b1;
        cyc();
        cyc();
        do_reset();
        m_valid = 1'b1;
        settle();
        chk("tp5_spur_rst", spur, 1'b1);
        chk("tp5_no_valid_rst", s0_valid | s1_valid, 1'b0);
        tick();

        // Random traffic against the model.
        idle();
        for (int i = 0; i < 600; i++) begin
            rst      = ($urandom_range(0, 59) == 0);
            s0_req   = ($urandom_range(0, 2) != 0);
            s1_req   = ($urandom_range(0, 2) != 0);
            s0_addr  = $urandom; s1_addr = $urandom;
            s0_we    = $urandom_range(0, 1); s1_we = $urandom_range(0, 1);
            s0_be    = 4'($urandom); s1_be = 4'($urandom);
            s0_wdata = $urandom; s1_wdata = $urandom;
            m_gnt    = ($urandom_range(0, 2) != 0);
            m_valid  = ($urandom_range(0, 4) < 2);
            m_rdata  = $urandom;
            m_error  = ($urandom_range(0, 7) == 0);
            cyc();
        end
        rst = 1'b0;
        idle();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_rr_arbiter_2to1.md
Name: mem_rr_arbiter_2to1

Overview:
Two-to-one round-robin arbiter that merges the core's instruction and data MEM master ports onto one MEM master port. Lets a split-port core share a single crossbar/memory slave port. Tracks outstanding transactions in an in-order ID FIFO and routes each response back to its originating requester.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, data width; be width is DATA_WIDTH/8
MAX_OUTSTANDING, 4, ID FIFO depth (>=1); max accepted-but-unanswered transactions

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
s0_mem_req  in  1  requester 0 (instr) request
s0_mem_gnt  out  1  requester 0 grant
s0_mem_addr  in  ADDR_WIDTH  requester 0 address
s0_mem_we  in  1  requester 0 write enable
s0_mem_be  in  DATA_WIDTH/8  requester 0 byte enables
s0_mem_wdata  in  DATA_WIDTH  requester 0 write data
s0_mem_valid  out  1  requester 0 response valid
s0_mem_rdata  out  DATA_WIDTH  requester 0 read data
s0_mem_error  out  1  requester 0 response error
s1_mem_*  same set as s0_mem_*  requester 1 (data)
m_mem_req  out  1  shared port request
m_mem_gnt  in  1  shared port grant
m_mem_addr  out  ADDR_WIDTH  muxed address
m_mem_we  out  1  muxed write enable
m_mem_be  out  DATA_WIDTH/8  muxed byte enables
m_mem_wdata  out  DATA_WIDTH  muxed write data
m_mem_valid  in  1  shared response valid
m_mem_rdata  in  DATA_WIDTH  shared read data
m_mem_error  in  1  shared response error
spurious_rsp_o  out  1  one-cycle pulse: m_mem_valid with no outstanding transaction

Behaviour:
- Clock clk_i; reset rst_i is synchronous and active-high.
- Handshake: request accepted in a cycle with req && gnt. Response arrives >=1 cycle later, strictly in order.
- Reset state: FIFO empty (count=0), lock cleared, last_grant=1 (s0 wins first tie). All outputs 0: gnt, valid, rdata, error, m_mem_req, m_mem_addr/we/be/wdata, spurious_rsp_o.
- full = (count == MAX_OUTSTANDING), taken from the registered count. A pop in the same cycle does not unblock.
- FSM ARB: sel = only requester asserting req; if both, the one != last_grant. m_mem_req = (s0_req|s1_req) && !full. If m_mem_req && !m_mem_gnt, latch sel and go to LOCKED.
- FSM LOCKED: sel is held and m_mem_req=1 regardless of the other requester. Return to ARB on m_mem_gnt. A requester may not drop req before gnt (protocol rule); if it does, return to ARB and deassert m_mem_req.
- Mux: m_mem_addr/we/be/wdata = fields of sel when m_mem_req=1, else 0.
- Grant: sN_mem_gnt = m_mem_gnt && m_mem_req && sel==N. Combinational, zero added latency.
- On handshake: push sel into FIFO, set last_grant=sel.
- Response: on m_mem_valid with count>0, pop head ID h. Drive sh_mem_valid=1, sh_mem_rdata=m_mem_rdata, sh_mem_error=m_mem_error in the same cycle (combinational). Other requester: valid/rdata/error = 0.
- m_mem_valid with count==0: dropped, spurious_rsp_o=1 for that cycle. This includes a response in the same cycle as the first handshake.
- Simultaneous push and pop: count unchanged, FIFO pointers both advance modulo MAX_OUTSTANDING.
- Reset mid-operation: FIFO and lock cleared immediately. Responses to pre-reset transactions are flagged spurious and not forwarded.
- count width $clog2(MAX_OUTSTANDING+1). Pointers wrap at MAX_OUTSTANDING (non-power-of-2 supported).

Test Plan:
- Only s0 requests addr 0x100, gnt same cycle, valid 1 cycle later with rdata 0xDEADBEEF -> s0_mem_gnt=1 on cycle 0; s0_mem_valid=1, rdata 0xDEADBEEF on cycle 1; s1 outputs all 0.
- s0 and s1 request continuously, m_mem_gnt=1 always -> grants alternate s0,s1,s0,s1; first grant to s0 after reset.
- s1 requests write (we=1, be=0xF, wdata=0x12345678) with m_mem_gnt=0 for 3 cycles while s0 raises req on cycle 1 -> m_mem_* holds s1 fields for all 4 cycles; s1 granted on cycle 3; s0 granted next.
- MAX_OUTSTANDING=4, gnt always 1, no responses -> exactly 4 handshakes, then m_mem_req=0. A single m_mem_valid re-enables m_mem_req next cycle. Responses route in grant order, with error=1 passed to the correct requester.
- m_mem_valid with FIFO empty, and again after rst_i asserted with 2 outstanding -> spurious_rsp_o pulses each time; no sN_mem_valid.
